// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter for the register file write port
// Two writeback sources share WE3/A3/WD3; a pending-write scoreboard tracks outstanding destinations.
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_req0_valid,
    input  logic [ADDR_W-1:0]        i_req0_addr,
    input  logic [DATA_W-1:0]        i_req0_data,
    output logic                     o_req0_ready,
    input  logic                     i_req1_valid,
    input  logic [ADDR_W-1:0]        i_req1_addr,
    input  logic [DATA_W-1:0]        i_req1_data,
    output logic                     o_req1_ready,
    input  logic                     i_issue_valid,
    input  logic [ADDR_W-1:0]        i_issue_addr,
    output logic                     o_we3,
    output logic [ADDR_W-1:0]        o_a3,
    output logic [DATA_W-1:0]        o_wd3,
    output logic [(2**ADDR_W)-1:0]   o_busy
);

    logic                     r_prio;
    logic                     r_we3;
    logic [ADDR_W-1:0]        r_a3;
    logic [DATA_W-1:0]        r_wd3;
    logic [(2**ADDR_W)-1:0]   r_busy;

    logic                     w_grant0;
    logic                     w_grant1;
    logic                     w_xfer;
    logic                     w_prio_nxt;
    logic [ADDR_W-1:0]        w_sel_addr;
    logic [DATA_W-1:0]        w_sel_data;
    logic [(2**ADDR_W)-1:0]   w_busy_nxt;

    // Grants are held low during reset so nothing is handshaken while the pipeline is clearing.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (i_rst_n) begin
            if (i_req0_valid && i_req1_valid) begin
                w_grant0 = ~r_prio;
                w_grant1 = r_prio;
            end else begin
                w_grant0 = i_req0_valid;
                w_grant1 = i_req1_valid;
            end
        end
    end

    assign w_xfer     = w_grant0 | w_grant1;
    assign w_sel_addr = w_grant1 ? i_req1_addr : i_req0_addr;
    assign w_sel_data = w_grant1 ? i_req1_data : i_req0_data;

    // Priority flips to the requester that did not just win; idle cycles keep it.
    always_comb begin
        w_prio_nxt = r_prio;
        if (w_xfer) begin
            w_prio_nxt = w_grant0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prio <= 1'b0;
        end else begin
            r_prio <= w_prio_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we3 <= 1'b0;
            r_a3  <= '0;
            r_wd3 <= '0;
        end else begin
            r_we3 <= w_xfer && (w_sel_addr != '0);
            if (w_xfer) begin
                r_a3  <= w_sel_addr;
                r_wd3 <= w_sel_data;
            end
        end
    end

    // Clear first, then set, so a new issue to the register being written keeps it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we3) begin
            w_busy_nxt[r_a3] = 1'b0;
        end
        if (i_issue_valid && (i_issue_addr != '0)) begin
            w_busy_nxt[i_issue_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_req0_ready = w_grant0;
    assign o_req1_ready = w_grant1;
    assign o_we3        = r_we3;
    assign o_a3         = r_a3;
    assign o_wd3        = r_wd3;
    assign o_busy       = r_busy;

endmodule
